// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - LEGv8 decode constants: opcodes, ID/EX control bit indices, ALUOp codes, XZR
package id_ex_stage_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CTRL_W  = 10;

    localparam logic [REG_AW-1:0] XZR = 5'd31;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam int unsigned CTRL_ALUSRC   = 9;
    localparam int unsigned CTRL_MEMTOREG = 8;
    localparam int unsigned CTRL_REGWRITE = 7;
    localparam int unsigned CTRL_MEMREAD  = 6;
    localparam int unsigned CTRL_MEMWRITE = 5;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam int unsigned CTRL_UNCOND   = 3;
    localparam int unsigned CTRL_REG2LOC  = 2;
    localparam int unsigned CTRL_ALUOP_LO = 0;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/id_ex_stage_control_decoder.sv
// rtl/id_ex_stage_control_decoder.sv - control_decoder: opcode[31:21] to the 10-bit ID/EX control word
module control_decoder
    import id_ex_stage_pkg::*;
(
    input  logic [10:0]       opcode,
    output logic [CTRL_W-1:0] ctrl
);

    always_comb begin
        ctrl = '0;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
            ctrl[CTRL_REGWRITE]            = 1'b1;
            ctrl[CTRL_ALUOP_LO +: 2]       = ALUOP_RTYPE;
        end else if (opcode == OP_LDUR) begin
            ctrl[CTRL_ALUSRC]              = 1'b1;
            ctrl[CTRL_MEMTOREG]            = 1'b1;
            ctrl[CTRL_REGWRITE]            = 1'b1;
            ctrl[CTRL_MEMREAD]             = 1'b1;
            ctrl[CTRL_ALUOP_LO +: 2]       = ALUOP_MEM;
        end else if (opcode == OP_STUR) begin
            ctrl[CTRL_ALUSRC]              = 1'b1;
            ctrl[CTRL_MEMWRITE]            = 1'b1;
            ctrl[CTRL_REG2LOC]             = 1'b1;
            ctrl[CTRL_ALUOP_LO +: 2]       = ALUOP_MEM;
        end else if (opcode[10:3] == OP_CBZ) begin
            ctrl[CTRL_BRANCH]              = 1'b1;
            ctrl[CTRL_REG2LOC]             = 1'b1;
            ctrl[CTRL_ALUOP_LO +: 2]       = ALUOP_CBZ;
        end else if (opcode[10:5] == OP_B) begin
            ctrl[CTRL_UNCOND]              = 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - LEGv8 decode stage with load-use stall and ID/EX register; optional ID_WB_BYPASS_EN
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic [INSTR_W-1:0]  IfId_Instr,
    input  logic [DATA_W-1:0]   IfId_PC,
    input  logic                IfId_Valid,
    input  logic                Flush,
    output logic [REG_AW-1:0]   RA,
    output logic [REG_AW-1:0]   RB,
    input  logic [DATA_W-1:0]   BusA,
    input  logic [DATA_W-1:0]   BusB,
    input  logic                WB_RegWr,
    input  logic [REG_AW-1:0]   WB_RW,
    input  logic [DATA_W-1:0]   WB_BusW,
    output logic                StallIF,
    output logic                IdEx_Valid,
    output logic [DATA_W-1:0]   IdEx_PC,
    output logic [DATA_W-1:0]   IdEx_RD1,
    output logic [DATA_W-1:0]   IdEx_RD2,
    output logic [DATA_W-1:0]   IdEx_Imm,
    output logic [REG_AW-1:0]   IdEx_Rn,
    output logic [REG_AW-1:0]   IdEx_Rm,
    output logic [REG_AW-1:0]   IdEx_Rd,
    output logic [CTRL_W-1:0]   IdEx_Ctrl
);

    logic [CTRL_W-1:0] dec_ctrl;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              load_use;

    control_decoder u_control_decoder (
        .opcode (IfId_Instr[31:21]),
        .ctrl   (dec_ctrl)
    );

    assign ctrl = IfId_Valid ? dec_ctrl : '0;
    assign RA   = IfId_Instr[9:5];
    assign RB   = ctrl[CTRL_REG2LOC] ? IfId_Instr[4:0] : IfId_Instr[20:16];

    always_comb begin
        imm = '0;
        if (ctrl[CTRL_ALUSRC])
            imm = {{(DATA_W-9){IfId_Instr[20]}}, IfId_Instr[20:12]};
        else if (ctrl[CTRL_BRANCH])
            imm = {{(DATA_W-19){IfId_Instr[23]}}, IfId_Instr[23:5]};
        else if (ctrl[CTRL_UNCOND])
            imm = {{(DATA_W-26){IfId_Instr[25]}}, IfId_Instr[25:0]};
    end

    // B reads no registers, so its Rn/Rm fields must not trigger a stall
    assign load_use = IdEx_Valid && IdEx_Ctrl[CTRL_MEMREAD] && (IdEx_Rd != XZR) &&
                      IfId_Valid && !ctrl[CTRL_UNCOND] &&
                      ((IdEx_Rd == RA) || (IdEx_Rd == RB));
    assign StallIF  = load_use && !Flush;

`ifdef ID_WB_BYPASS_EN
    assign opnd_a = (WB_RegWr && WB_RW == RA && RA != XZR) ? WB_BusW : BusA;
    assign opnd_b = (WB_RegWr && WB_RW == RB && RB != XZR) ? WB_BusW : BusB;
`else
    logic unused_wb;
    assign unused_wb = ^{WB_RegWr, WB_RW, WB_BusW};
    assign opnd_a    = BusA;
    assign opnd_b    = BusB;
`endif

    always_ff @(posedge Clk) begin
        if (Reset || Flush || load_use) begin
            IdEx_Valid <= 1'b0;
            IdEx_PC    <= '0;
            IdEx_RD1   <= '0;
            IdEx_RD2   <= '0;
            IdEx_Imm   <= '0;
            IdEx_Rn    <= '0;
            IdEx_Rm    <= '0;
            IdEx_Rd    <= '0;
            IdEx_Ctrl  <= '0;
        end else begin
            IdEx_Valid <= IfId_Valid;
            IdEx_PC    <= IfId_PC;
            IdEx_RD1   <= opnd_a;
            IdEx_RD2   <= opnd_b;
            IdEx_Imm   <= imm;
            IdEx_Rn    <= IfId_Instr[9:5];
            IdEx_Rm    <= RB;
            IdEx_Rd    <= IfId_Instr[4:0];
            IdEx_Ctrl  <= ctrl;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and random checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;

    logic        Clk = 1'b0;
    logic        Reset, IfId_Valid, Flush, WB_RegWr, StallIF, IdEx_Valid;
    logic [31:0] IfId_Instr;
    logic [63:0] IfId_PC, BusA, BusB, WB_BusW;
    logic [63:0] IdEx_PC, IdEx_RD1, IdEx_RD2, IdEx_Imm;
    logic [4:0]  RA, RB, WB_RW, IdEx_Rn, IdEx_Rm, IdEx_Rd;
    logic [9:0]  IdEx_Ctrl;

    int checks = 0;
    int errors = 0;

    logic        m_known = 1'b0;
    logic        m_valid, m_memread;
    logic [4:0]  m_rd;
    logic        exp_stall;
    logic        last_stall;

    always #5 Clk = ~Clk;

    id_ex_stage dut (
        .Clk(Clk), .Reset(Reset), .IfId_Instr(IfId_Instr), .IfId_PC(IfId_PC),
        .IfId_Valid(IfId_Valid), .Flush(Flush), .RA(RA), .RB(RB),
        .BusA(BusA), .BusB(BusB), .WB_RegWr(WB_RegWr), .WB_RW(WB_RW),
        .WB_BusW(WB_BusW), .StallIF(StallIF), .IdEx_Valid(IdEx_Valid),
        .IdEx_PC(IdEx_PC), .IdEx_RD1(IdEx_RD1), .IdEx_RD2(IdEx_RD2),
        .IdEx_Imm(IdEx_Imm), .IdEx_Rn(IdEx_Rn), .IdEx_Rm(IdEx_Rm),
        .IdEx_Rd(IdEx_Rd), .IdEx_Ctrl(IdEx_Ctrl)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control word per instruction class: {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Uncond,Reg2Loc,ALUOp}
    function automatic logic [9:0] model_ctrl(input logic [31:0] ins, input logic v);
        if (!v) return 10'b0;
        casez (ins[31:21])
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: return 10'b0010000010;
            11'b11111000010:                  return 10'b1111000000;
            11'b11111000000:                  return 10'b1000100100;
            11'b10110100???:                  return 10'b0000010101;
            11'b000101?????:                  return 10'b0000001000;
            default:                          return 10'b0;
        endcase
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [9:0] c);
        longint v = 0;
        if (c[9]) begin
            v = longint'(ins[20:12]);
            if (v >= 256) v -= 512;
        end else if (c[4]) begin
            v = longint'(ins[23:5]);
            if (v >= (longint'(1) << 18)) v -= (longint'(1) << 19);
        end else if (c[3]) begin
            v = longint'(ins[25:0]);
            if (v >= (longint'(1) << 25)) v -= (longint'(1) << 26);
        end
        return v;
    endfunction

    function automatic logic [31:0] r_ins(input logic [10:0] op, input logic [4:0] rm, rn, rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] d_ins(input logic [10:0] op, input logic [8:0] im, input logic [4:0] rn, rt);
        return {op, im, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] cb_ins(input logic [18:0] im, input logic [4:0] rt);
        return {8'b10110100, im, rt};
    endfunction
    function automatic logic [31:0] b_ins(input logic [25:0] im);
        return {6'b000101, im};
    endfunction

    task automatic step(input logic rst, input logic v, input logic fl, input logic [31:0] ins,
                        input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b);
        logic [9:0]  c;
        logic [4:0]  ra, rb;
        logic [63:0] rd1, rd2;
        logic        lu;
        Reset = rst; IfId_Valid = v; Flush = fl; IfId_Instr = ins;
        IfId_PC = pc; BusA = a; BusB = b;
        #1;
        c   = model_ctrl(ins, v);
        ra  = ins[9:5];
        rb  = c[2] ? ins[4:0] : ins[20:16];
        lu  = m_known && m_valid && m_memread && m_rd != 5'd31 && v && !c[3] &&
              (m_rd == ra || m_rd == rb);
        exp_stall  = lu && !fl;
        last_stall = StallIF;
        rd1 = a;
        rd2 = b;
`ifdef ID_WB_BYPASS_EN
        if (WB_RegWr && WB_RW == ra && ra != 5'd31) rd1 = WB_BusW;
        if (WB_RegWr && WB_RW == rb && rb != 5'd31) rd2 = WB_BusW;
`endif
        chk("ra", 64'(RA), 64'(ra));
        chk("rb", 64'(RB), 64'(rb));
        if (m_known || rst) chk("stall_if", 64'(StallIF), 64'(exp_stall));
        @(posedge Clk);
        #1;
        if (rst || fl || lu) begin
            m_valid = 1'b0; m_memread = 1'b0; m_rd = 5'd0;
            chk("bubble_valid", 64'(IdEx_Valid), 64'd0);
            chk("bubble_ctrl", 64'(IdEx_Ctrl), 64'd0);
            chk("bubble_fields", {IdEx_PC ^ IdEx_RD1 ^ IdEx_RD2 ^ IdEx_Imm},  64'd0);
            chk("bubble_regs", 64'({IdEx_Rn, IdEx_Rm, IdEx_Rd}), 64'd0);
        end else begin
            m_valid = v; m_memread = c[6]; m_rd = ins[4:0];
            chk("valid", 64'(IdEx_Valid), 64'(v));
            chk("ctrl", 64'(IdEx_Ctrl), 64'(c));
            chk("pc", IdEx_PC, pc);
            chk("rd1", IdEx_RD1, rd1);
            chk("rd2", IdEx_RD2, rd2);
            chk("imm", IdEx_Imm, model_imm(ins, c));
            chk("rn", 64'(IdEx_Rn), 64'(ins[9:5]));
            chk("rm", 64'(IdEx_Rm), 64'(rb));
            chk("rd", 64'(IdEx_Rd), 64'(ins[4:0]));
        end
        if (rst) m_known = 1'b1;
    endtask

    function automatic logic [4:0] rnd_reg();
        int r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] rnd_ins();
        logic [10:0] rops [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
        case ($urandom_range(0, 6))
            0, 1:    return r_ins(rops[$urandom_range(0, 3)], rnd_reg(), rnd_reg(), rnd_reg());
            2:       return d_ins(11'b11111000010, 9'($urandom), rnd_reg(), rnd_reg());
            3:       return d_ins(11'b11111000000, 9'($urandom), rnd_reg(), rnd_reg());
            4:       return cb_ins(19'($urandom), rnd_reg());
            5:       return b_ins(26'($urandom));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        logic [63:0] pc;
        WB_RegWr = 1'b0; WB_RW = 5'd0; WB_BusW = 64'd0;

        step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 64'd0, 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 64'd0, 64'd0);
        chk("reset_stall", 64'(last_stall), 64'd0);

        step(1'b0, 1'b1, 1'b0, r_ins(11'b10001011000, 5'd2, 5'd1, 5'd3), 64'h100, 64'd5, 64'd7);
        chk("add_rd1", IdEx_RD1, 64'd5);
        chk("add_rd2", IdEx_RD2, 64'd7);
        chk("add_ctrl", 64'(IdEx_Ctrl), 64'h082);

        step(1'b0, 1'b1, 1'b0, d_ins(11'b11111000010, 9'd8, 5'd1, 5'd2), 64'h104, 64'd1, 64'd2);
        step(1'b0, 1'b1, 1'b0, r_ins(11'b10001011000, 5'd4, 5'd2, 5'd3), 64'h108, 64'd3, 64'd4);
        chk("lu_stall", 64'(last_stall), 64'd1);
        chk("lu_bubble", 64'(IdEx_Valid), 64'd0);
        step(1'b0, 1'b1, 1'b0, r_ins(11'b10001011000, 5'd4, 5'd2, 5'd3), 64'h108, 64'd3, 64'd4);
        chk("lu_one_cycle", 64'(last_stall), 64'd0);
        chk("lu_add_enters", 64'(IdEx_Valid), 64'd1);

        step(1'b0, 1'b1, 1'b0, d_ins(11'b11111000010, 9'd0, 5'd1, 5'd31), 64'h10c, 64'd1, 64'd2);
        step(1'b0, 1'b1, 1'b0, r_ins(11'b10001011000, 5'd4, 5'd31, 5'd3), 64'h110, 64'd0, 64'd4);
        chk("xzr_no_stall", 64'(last_stall), 64'd0);

        step(1'b0, 1'b1, 1'b0, d_ins(11'b11111000010, 9'd8, 5'd1, 5'd2), 64'h114, 64'd1, 64'd2);
        step(1'b0, 1'b1, 1'b1, r_ins(11'b10001011000, 5'd4, 5'd2, 5'd3), 64'h118, 64'd3, 64'd4);
        chk("flush_no_stall", 64'(last_stall), 64'd0);
        chk("flush_valid", 64'(IdEx_Valid), 64'd0);

        step(1'b0, 1'b1, 1'b0, cb_ins(19'h7FFFC, 5'd5), 64'h11c, 64'd0, 64'd0);
        chk("cbz_imm", IdEx_Imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("cbz_rm", 64'(IdEx_Rm), 64'd5);

`ifdef ID_WB_BYPASS_EN
        WB_RegWr = 1'b1; WB_RW = 5'd1; WB_BusW = 64'd9;
        step(1'b0, 1'b1, 1'b0, r_ins(11'b10001011000, 5'd2, 5'd1, 5'd3), 64'h120, 64'd5, 64'd7);
        chk("bypass_rd1", IdEx_RD1, 64'd9);
        WB_RegWr = 1'b0;
`endif

        ins = rnd_ins();
        pc  = 64'h200;
        for (int i = 0; i < 400; i++) begin
`ifdef ID_WB_BYPASS_EN
            WB_RegWr = 1'($urandom); WB_RW = rnd_reg(); WB_BusW = {$urandom, $urandom};
`else
            WB_RegWr = 1'($urandom); WB_RW = 5'($urandom); WB_BusW = {$urandom, $urandom};
`endif
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) == 0), ins, pc, {$urandom, $urandom}, {$urandom, $urandom});
            if (!exp_stall) begin
                ins = rnd_ins();
                pc  = pc + 64'd4;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
